// File: rtl/sa_pkg.sv
// Shared types and helpers for the N x N systolic matrix multiplier.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sa_state_t;

  // Accumulator width: full product plus headroom for N summed products.
  function automatic int unsigned sa_calc_aw(input int unsigned n, input int unsigned dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/sa_pe.sv
// Processing element: multiply-accumulate, forwarding a right and b down.
module sa_pe #(
  parameter int unsigned DW = 4,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          sgn,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned EW = AW - PW;

  logic [DW-1:0] a_out_q, a_out_d;
  logic [DW-1:0] b_out_q, b_out_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [PW-1:0] a_x, b_x, prod;
  logic [AW-1:0] prod_x;

  // Extend operands to product width so one multiplier serves both modes.
  always_comb begin
    a_x     = sgn ? {{DW{a_in[DW-1]}}, a_in} : {{DW{1'b0}}, a_in};
    b_x     = sgn ? {{DW{b_in[DW-1]}}, b_in} : {{DW{1'b0}}, b_in};
    prod    = a_x * b_x;
    prod_x  = sgn ? {{EW{prod[PW-1]}}, prod} : {{EW{1'b0}}, prod};
    a_out_d = a_in;
    b_out_d = b_in;
    acc_d   = acc_q + prod_x;
    if (clr) begin
      a_out_d = '0;
      b_out_d = '0;
      acc_d   = '0;
    end
  end

  // PE state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out_q <= '0;
      b_out_q <= '0;
      acc_q   <= '0;
    end else begin
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      acc_q   <= acc_d;
    end
  end

  assign a_out = a_out_q;
  assign b_out = b_out_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic array computing C = A x B from N streamed beats.
module systolic_array_nxn
  import sa_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 4,
  parameter int unsigned AW = sa_calc_aw(N, DW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   a_col,
  input  logic [N*DW-1:0]   b_row,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N*N*AW-1:0] res_data,
  output logic              busy
);

  localparam int unsigned CW = $clog2(2 * N);

  sa_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          res_valid_q, res_valid_d;
  logic          busy_q, busy_d;
  logic          sgn_q, sgn_d;
  logic          clr_c;
  logic          beat_c;

  logic [DW-1:0] a_w [N][N];
  logic [DW-1:0] b_w [N][N];
  logic [AW-1:0] acc_w [N][N];
  logic [DW-1:0] a_edge_unused [N];
  logic [DW-1:0] b_edge_unused [N];

  assign clr_c  = (state_q == ST_IDLE) && start;
  assign beat_c = in_valid && in_ready_q;

  // Next-state and registered-output logic; one counter tracks beats, then drain.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    sgn_d       = sgn_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          cnt_d      = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          sgn_d      = signed_mode;
        end
      end
      ST_LOAD: begin
        if (beat_c) begin
          if (cnt_q == CW'(N - 1)) begin
            state_d    = ST_DRAIN;
            cnt_d      = '0;
            in_ready_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(2 * N - 2)) begin
          state_d     = ST_DONE;
          cnt_d       = '0;
          res_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sgn_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      sgn_q       <= sgn_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

  // Skew lines: row/column i sees i extra stages; zeros enter when no beat is taken.
  for (genvar gi = 0; gi < int'(N); gi++) begin : g_skew
    logic [DW-1:0] a_sk_q [gi+1];
    logic [DW-1:0] a_sk_d [gi+1];
    logic [DW-1:0] b_sk_q [gi+1];
    logic [DW-1:0] b_sk_d [gi+1];

    // Shift one stage per cycle, loading the new beat (or a bubble) at stage 0.
    always_comb begin
      for (int s = 0; s <= gi; s++) begin
        a_sk_d[s] = '0;
        b_sk_d[s] = '0;
      end
      if (!clr_c) begin
        a_sk_d[0] = beat_c ? a_col[gi*DW +: DW] : '0;
        b_sk_d[0] = beat_c ? b_row[gi*DW +: DW] : '0;
        for (int s = 0; s < gi; s++) begin
          a_sk_d[s+1] = a_sk_q[s];
          b_sk_d[s+1] = b_sk_q[s];
        end
      end
    end

    // Skew stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= gi; s++) begin
          a_sk_q[s] <= '0;
          b_sk_q[s] <= '0;
        end
      end else begin
        a_sk_q <= a_sk_d;
        b_sk_q <= b_sk_d;
      end
    end

    assign a_w[gi][0] = a_sk_q[gi];
    assign b_w[0][gi] = b_sk_q[gi];
  end

  // PE grid: a flows right along rows, b flows down along columns.
  for (genvar gi = 0; gi < int'(N); gi++) begin : g_row
    for (genvar gj = 0; gj < int'(N); gj++) begin : g_col
      logic [DW-1:0] a_fwd;
      logic [DW-1:0] b_fwd;

      sa_pe #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_c),
        .sgn  (sgn_q),
        .a_in (a_w[gi][gj]),
        .b_in (b_w[gi][gj]),
        .a_out(a_fwd),
        .b_out(b_fwd),
        .acc  (acc_w[gi][gj])
      );

      if (gj < int'(N) - 1) begin : g_a_next
        assign a_w[gi][gj+1] = a_fwd;
      end else begin : g_a_edge
        assign a_edge_unused[gi] = a_fwd;
      end

      if (gi < int'(N) - 1) begin : g_b_next
        assign b_w[gi+1][gj] = b_fwd;
      end else begin : g_b_edge
        assign b_edge_unused[gj] = b_fwd;
      end

      assign res_data[(gi*int'(N)+gj)*int'(AW) +: AW] = acc_w[gi][gj];
    end
  end

endmodule
